rsa_seg_display: RTL and testbench
==================================

// Module: rsa_seg_display
// PURPOSE
//  Downstream of the RSA core. Accepts one DATA_W-bit result (key, ciphertext, debug value)
//  over a valid/ready handshake. Converts it to decimal with a sequential double-dabble,
//  one input bit per cycle, and drives DIGITS registered seven-segment patterns.
//  Replaces the core's direct seg driving; the core only hands over a word.
// PARAMETERS
//  DATA_W  64  width of the binary input value
//  DIGITS  8   number of decimal digits / seg outputs (BCD register = 4*DIGITS bits)
// PORTS
//  clk       in   1            single clock; all state on posedge clk
//  rst       in   1            synchronous, active-high reset
//  in_valid  in   1            in_data valid
//  in_ready  out  1            block can accept (IDLE only)
//  in_data   in   DATA_W       unsigned binary value to display
//  busy      out  1            conversion in progress
//  overflow  out  1            last displayed value >= 10**DIGITS
//  seg       out  8 x DIGITS   seg[0]=least-significant digit; bit7=dp (always 0), bits6:0=g..a
// BEHAVIOUR
//  Reset: seg[*]=8'h00, overflow=0, busy=0, in_ready=0 while rst high; state=IDLE.
//  FSM: IDLE -> CONVERT -> UPDATE -> IDLE.
//   IDLE: in_ready=1, busy=0. If in_valid&&in_ready at edge N:
//     load shift reg=in_data; clear BCD and sticky ovf; load bit counter=DATA_W.
//   CONVERT (edges N+1..N+DATA_W): per cycle, every BCD nibble >=5 gets +3.
//     Then {BCD,shift} <<= 1. If the top nibble's MSB is 1 before the shift, set sticky ovf.
//     Decrement counter; leave at 0. in_ready=0, busy=1.
//   UPDATE (edge N+DATA_W+1): seg[i]=SEG_NUM[bcd digit i] and overflow=ovf.
//     If ovf, every seg[i]=SEG_DASH (8'b01000000). Return to IDLE.
//     in_ready is high in the following cycle.
//  Latency: handshake to new seg = DATA_W+1 cycles (65 default). Throughput: one value per DATA_W+2 cycles.
//  seg/overflow hold their last value through IDLE/CONVERT; no partial values are ever visible.
//  in_valid during CONVERT/UPDATE is ignored (in_ready=0); the data is not latched.
//  The upstream stage must hold the value until the handshake completes.
//  in_data is sampled only at the handshake edge; later changes have no effect.
//  rst asserted mid-CONVERT aborts the conversion; all outputs take reset values on the next edge.
//  Boundary values: 0 shows "00000000"; 10**DIGITS-1 shows all 9s with overflow=0.
//  10**DIGITS and above set overflow=1 and show dashes.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined: at UPDATE, seg[i]=8'h00 for every zero digit above the highest nonzero digit.
//   seg[0] is never blanked, so 0 shows a single "0". Has no effect on the overflow dash display.
//  Undefined: all DIGITS digits are shown, including leading zeros.
// STRUCTURE
//  rsa_pkg: SEG_NUM[0:9] table (8'b00111111 .. 8'b01101111), SEG_DASH, SEG_BLANK=8'h00,
//   typedef enum logic [1:0] {DISP_IDLE, DISP_CONVERT, DISP_UPDATE} disp_state_t.
//  Sub-module dabble_digit: combinational per-nibble add-3 cell (4b in -> 4b out).
//   Instantiated DIGITS times in a generate loop.
// TESTING
//  T1 reset, then in_data=0 -> after 65 cycles every seg[i]=8'h3F, overflow=0, in_ready back high on cycle 66.
//  T2 in_data=12345678 -> seg[0]=8'h7F ('8') .. seg[7]=8'h06 ('1'); latency exactly 65 cycles from handshake.
//  T3 in_data=99999999 -> all seg=8'h6F, overflow=0.
//     Then 100000000 and 64'hFFFF_FFFF_FFFF_FFFF -> overflow=1, all seg=8'h40.
//  T4 hold in_valid high with values A then B during CONVERT -> only A converts.
//     B is accepted only on the first IDLE cycle; seg never shows an intermediate value.
//  T5 assert rst for 1 cycle at cycle 30 of CONVERT -> seg=8'h00, busy=0.
//     Next value 42 converts correctly, with no residue from the aborted run.
//  T6 (LEAD_ZERO_BLANK_EN) in_data=42 -> seg[0]=8'h5B, seg[1]=8'h66, seg[2..7]=8'h00.
//     in_data=0 -> seg[0]=8'h3F, rest 8'h00.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared seven-segment encodings and display FSM state type for the RSA result display.
package rsa_pkg;

    typedef enum logic [1:0] {
        DISP_IDLE    = 2'd0,
        DISP_CONVERT = 2'd1,
        DISP_UPDATE  = 2'd2
    } disp_state_t;

    // Segment bit order is dp,g,f,e,d,c,b,a; dp is never lit.
    localparam logic [7:0] SEG_NUM [10] = '{
        8'b00111111, 8'b00000110, 8'b01011011, 8'b01001111, 8'b01100110,
        8'b01101101, 8'b01111101, 8'b00000111, 8'b01111111, 8'b01101111
    };
    localparam logic [7:0] SEG_DASH  = 8'b01000000;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] seg_of(input logic [3:0] digit);
        logic [7:0] pat;
        if (digit <= 4'd9) begin
            pat = SEG_NUM[digit];
        end else begin
            pat = SEG_BLANK;
        end
        return pat;
    endfunction

endpackage

// File: rtl/dabble_digit.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added before the shift.
module dabble_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add-3 correction so the following left shift carries into the next decimal digit.
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/rsa_seg_display.sv
// Binary-to-decimal seven-segment display for RSA results, one input bit per cycle.
// Optional LEAD_ZERO_BLANK_EN blanks zero digits above the highest nonzero digit.
module rsa_seg_display
    import rsa_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DIGITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   busy,
    output logic                   overflow,
    output logic [DIGITS-1:0][7:0] seg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    disp_state_t             state_r;
    logic [DATA_W-1:0]       shift_r;
    logic [BCD_W-1:0]        bcd_r;
    logic [BCD_W-1:0]        adj_s;
    logic                    ovf_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [DIGITS-1:0]       blank_s;
    logic [DIGITS-1:0][7:0]  seg_next_s;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dabble
            dabble_digit u_dabble (
                .din  (bcd_r[4*g +: 4]),
                .dout (adj_s[4*g +: 4])
            );
        end
    endgenerate

`ifdef LEAD_ZERO_BLANK_EN
    logic zero_above_s;

    // Mark leading zero digits; digit 0 always stays visible.
    always_comb begin
        blank_s      = '0;
        zero_above_s = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (zero_above_s && (bcd_r[4*i +: 4] == 4'd0)) begin
                blank_s[i] = 1'b1;
            end else begin
                zero_above_s = 1'b0;
            end
        end
    end
`else
    // Leading zeros are shown.
    always_comb begin
        blank_s = '0;
    end
`endif

    // Segment patterns for the finished conversion; dashes win over blanking.
    always_comb begin
        seg_next_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_r) begin
                seg_next_s[i] = SEG_DASH;
            end else if (blank_s[i]) begin
                seg_next_s[i] = SEG_BLANK;
            end else begin
                seg_next_s[i] = seg_of(bcd_r[4*i +: 4]);
            end
        end
    end

    // Display FSM: accept a word, shift it through the BCD register, then publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= DISP_IDLE;
            shift_r  <= '0;
            bcd_r    <= '0;
            ovf_r    <= 1'b0;
            cnt_r    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            seg      <= '0;
        end else begin
            case (state_r)
                DISP_IDLE: begin
                    if (in_valid && in_ready) begin
                        shift_r  <= in_data;
                        bcd_r    <= '0;
                        ovf_r    <= 1'b0;
                        cnt_r    <= CNT_W'(DATA_W);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= DISP_CONVERT;
                    end else begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                DISP_CONVERT: begin
                    // A set MSB after correction would carry out of the top digit.
                    if (adj_s[BCD_W-1]) begin
                        ovf_r <= 1'b1;
                    end
                    bcd_r   <= {adj_s[BCD_W-2:0], shift_r[DATA_W-1]};
                    shift_r <= {shift_r[DATA_W-2:0], 1'b0};
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= DISP_UPDATE;
                    end
                end
                DISP_UPDATE: begin
                    seg      <= seg_next_s;
                    overflow <= ovf_r;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    state_r  <= DISP_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= DISP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_seg_display.sv
// Self-checking bench for rsa_seg_display: scoreboard of expected displays, directed steps.
module tb_rsa_seg_display;

    localparam int DATA_W = 64;
    localparam int DIGITS = 8;

    typedef struct packed {
        logic [63:0] seg;
        logic        ovf;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic                   busy;
    logic                   overflow;
    logic [DIGITS-1:0][7:0] seg;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    rsa_seg_display #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] v);
        exp_t       e;
        logic [7:0] tab [10];
        logic [3:0] d [8];
        logic [63:0] r;
        bit         lead;
        tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        e.ovf = (v >= 64'd100000000);
        r = v;
        for (int i = 0; i < 8; i++) begin
            d[i] = 4'(r % 64'd10);
            r    = r / 64'd10;
        end
        for (int i = 0; i < 8; i++) begin
            e.seg[8*i +: 8] = e.ovf ? 8'h40 : tab[d[i]];
        end
`ifdef LEAD_ZERO_BLANK_EN
        if (!e.ovf) begin
            lead = 1'b1;
            for (int i = 7; i > 0; i--) begin
                if (lead && d[i] == 4'd0) e.seg[8*i +: 8] = 8'h00;
                else lead = 1'b0;
            end
        end
`else
        lead = 1'b0;
`endif
        return e;
    endfunction

    // Wait for ready, drive one word, and leave the bench #1 after the handshake edge.
    task automatic handshake(input logic [63:0] v, input bit keep, input logic [63:0] after_data);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = v;
        sb_q.push_back(model(v));
        @(posedge clk);
        #1;
        in_valid = keep;
        in_data  = after_data;
    endtask

    // Conversion window: display must hold, then update exactly DATA_W+1 edges after handshake.
    task automatic finish_conv(input string tag);
        logic [63:0] prev_seg;
        logic        prev_ovf;
        bit          stable;
        exp_t        e;
        prev_seg = seg;
        prev_ovf = overflow;
        stable   = 1'b1;
        repeat (DATA_W) begin
            @(posedge clk);
            #1;
            if (seg !== prev_seg || overflow !== prev_ovf || in_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        check({tag, "_hold"}, {63'd0, stable}, 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_sb_nonempty"}, {63'd0, sb_q.size() != 0}, 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_seg"}, seg, e.seg);
            check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, e.ovf});
        end
        check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", seg, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // T1 zero
        handshake(64'd0, 1'b0, 64'hDEAD_BEEF_0000_0001);
        finish_conv("t1_zero");

        // T2 mixed digits
        handshake(64'd12345678, 1'b0, 64'd99);
        finish_conv("t2_12345678");
        check("t2_digit0", {56'd0, seg[0]}, 64'h7F);
        check("t2_digit7", {56'd0, seg[7]}, 64'h06);

        // T3 boundaries
        handshake(64'd99999999, 1'b0, 64'd0);
        finish_conv("t3_max");
        handshake(64'd100000000, 1'b0, 64'd1);
        finish_conv("t3_over");
        handshake(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd5);
        finish_conv("t3_allones");

        // T4 valid held high: A converts, B taken on first IDLE cycle
        handshake(64'd31415926, 1'b1, 64'd27182818);
        finish_conv("t4_a");
        sb_q.push_back(model(64'd27182818));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 64'd11111111;
        check("t4_b_accepted", {63'd0, busy}, 64'd1);
        finish_conv("t4_b");

        // T5 reset in the middle of a conversion
        handshake(64'd77777777, 1'b0, 64'd3);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_seg", seg, 64'd0);
        check("t5_rst_busy", {63'd0, busy}, 64'd0);
        check("t5_rst_ovf", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_back());
        handshake(64'd42, 1'b0, 64'd8);
        finish_conv("t5_after");

`ifdef LEAD_ZERO_BLANK_EN
        // T6 blanking constants
        check("t6_42", seg, {48'd0, 8'h66, 8'h5B});
        handshake(64'd0, 1'b0, 64'd4);
        finish_conv("t6_zero");
        check("t6_zero_const", seg, 64'h0000_0000_0000_003F);
`endif

        // Random values, in range and arbitrary 64-bit
        for (int k = 0; k < 3; k++) begin
            handshake(64'($urandom_range(0, 99999999)), 1'b0, {$urandom, $urandom});
            finish_conv("rand_small");
        end
        handshake({$urandom, $urandom}, 1'b0, 64'd0);
        finish_conv("rand_wide");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
